// File: rtl/mul_sched_pkg.sv
// Shared definitions for the two-requester shift/subtract scaling scheduler:
// scale codes, FSM state encoding and the default operand width.
package mul_sched_pkg;

  localparam int DW_DEFAULT = 8;

  localparam logic [1:0] SEL_X1 = 2'b00;
  localparam logic [1:0] SEL_X3 = 2'b01;
  localparam logic [1:0] SEL_X7 = 2'b10;
  localparam logic [1:0] SEL_X8 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sched_if.sv
// Request/result bundle between two requesters, the scheduler and the result consumer.
interface mul_sched_if
  import mul_sched_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int OW = DW + 3
);

  logic          req0_valid;
  logic [DW-1:0] req0_d;
  logic [1:0]    req0_sel;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_d;
  logic [1:0]    req1_sel;
  logic          req1_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_id;
  logic          out_ready;
  logic          busy;
  logic [7:0]    op_count;

  // Scheduler side
  modport slave (
    input  req0_valid, req0_d, req0_sel, req1_valid, req1_d, req1_sel, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, busy, op_count
  );

  // Requesters and consumer side
  modport master (
    output req0_valid, req0_d, req0_sel, req1_valid, req1_d, req1_sel, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, busy, op_count
  );

endinterface

// File: rtl/mul_sched_shift_scale.sv
// Combinational constant scaler (x1/x3/x7/x8) built from shifts and one subtract.
module shift_scale
  import mul_sched_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int OW = DW + 3
) (
  input  logic [DW-1:0] d,
  input  logic [1:0]    sel,
  output logic [OW-1:0] res
);

  logic [OW-1:0] ext;

  // Widen before shifting so x8 of the largest operand keeps its top bits.
  assign ext = OW'(d);

  always_comb begin
    // NOTE: default assignment first so no path leaves res unassigned (no latch).
    res = ext;
    case (sel)
      SEL_X1: res = ext;
      SEL_X3: res = (ext << 2) - ext;
      SEL_X7: res = (ext << 3) - ext;
      SEL_X8: res = ext << 3;
    endcase
  end

endmodule

// File: rtl/mul_sched.sv
// Two-requester scheduler: fair arbitration in IDLE, one-cycle scaling in CALC,
// result held in DONE until the consumer accepts it.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int OW = DW + 3
) (
  input  logic         clk,
  input  logic         rst,
  mul_sched_if.slave   bus
);

  state_e        state_q, state_d;
  logic [DW-1:0] d_q;
  logic [1:0]    sel_q;
  logic          id_q;
  logic          last_id_q;
  logic [OW-1:0] out_data_q;
  logic [7:0]    op_count_q;
  logic [OW-1:0] scaled;
  logic          grant0, grant1, accept, handshake;

  shift_scale #(.DW(DW), .OW(OW)) u_scale (
    .d   (d_q),
    .sel (sel_q),
    .res (scaled)
  );

  // Grants are gated by rst so no requester sees ready while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_id_q;
        grant1 = !last_id_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign accept    = grant0 | grant1;
  assign handshake = (state_q == DONE) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_id resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      sel_q      <= SEL_X1;
      id_q       <= 1'b0;
      last_id_q  <= 1'b1;
      out_data_q <= '0;
      op_count_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (accept) begin
        d_q   <= grant1 ? bus.req1_d   : bus.req0_d;
        sel_q <= grant1 ? bus.req1_sel : bus.req0_sel;
        id_q  <= grant1;
      end
      if (state_q == CALC) out_data_q <= scaled;
      if (handshake) begin
        last_id_q  <= id_q;
        op_count_q <= op_count_q + 8'd1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_data   = out_data_q;
  assign bus.out_id     = id_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mul_sched;
  import mul_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mul_sched_if #(.DW(8), .OW(11)) bus ();

  mul_sched #(.DW(8), .OW(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scale_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 1;
      2'b01:   return 3;
      2'b10:   return 7;
      default: return 8;
    endcase
  endfunction

  // Transaction-level model: an operation is "in flight" for a number of cycles
  // since acceptance; the result appears two cycles after the accept cycle.
  int m_age   = 0;
  int m_res   = 0;
  int m_count = 0;
  bit m_id    = 0;
  bit m_last  = 1;

  always @(negedge clk) begin
    bit g0, g1, idle;
    logic [7:0] dsel;
    logic [1:0] ssel;
    if (!rst) begin
      check("rst_req0_ready", bus.req0_ready, 0);
      check("rst_req1_ready", bus.req1_ready, 0);
      check("rst_out_valid",  bus.out_valid, 0);
      check("rst_out_data",   bus.out_data, 0);
      check("rst_out_id",     bus.out_id, 0);
      check("rst_op_count",   bus.op_count, 0);
      check("rst_busy",       bus.busy, 0);
      m_age = 0; m_count = 0; m_last = 1; m_id = 0; m_res = 0;
    end else begin
      idle = (m_age == 0);
      g0 = 0; g1 = 0;
      if (idle) begin
        if (bus.req0_valid && bus.req1_valid) begin
          g0 = (m_last == 1'b1);
          g1 = (m_last == 1'b0);
        end else begin
          g0 = bus.req0_valid;
          g1 = bus.req1_valid;
        end
      end
      check("req0_ready", bus.req0_ready, g0);
      check("req1_ready", bus.req1_ready, g1);
      check("out_valid",  bus.out_valid, (m_age == 2));
      check("busy",       bus.busy, !idle);
      check("op_count",   bus.op_count, m_count);
      if (m_age == 2) begin
        check("out_data", bus.out_data, m_res);
        check("out_id",   bus.out_id, m_id);
      end
      if (g0 || g1) begin
        m_id  = g1;
        dsel  = g1 ? bus.req1_d : bus.req0_d;
        ssel  = g1 ? bus.req1_sel : bus.req0_sel;
        m_res = int'(dsel) * scale_of(ssel);
        m_age = 1;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2 && bus.out_ready) begin
        m_age   = 0;
        m_last  = m_id;
        m_count = (m_count + 1) % 256;
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [7:0] d, input logic [1:0] sel);
    if (id) begin
      bus.req1_valid = v; bus.req1_d = d; bus.req1_sel = sel;
    end else begin
      bus.req0_valid = v; bus.req0_d = d; bus.req0_sel = sel;
    end
  endtask

  task automatic wait_ready(input bit id, input string name);
    bit got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        got = 1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  task automatic wait_valid(input string name);
    bit got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic run_op(input bit id, input logic [7:0] d, input logic [1:0] sel,
                        input int exp, input string name);
    set_req(id, 1, d, sel);
    wait_ready(id, {name, "_ready"});
    @(posedge clk); #1;
    set_req(id, 0, d, sel);
    wait_valid({name, "_valid"});
    check({name, "_data"}, bus.out_data, exp);
    check({name, "_id"}, bus.out_id, id);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int n;
    bit got;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 0, 8'd0, 2'b00);
    set_req(1, 0, 8'd0, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single req0 operation with explicit latency checks
    set_req(0, 1, 8'd143, 2'b00);
    wait_ready(0, "t1_ready");
    @(posedge clk); #1;
    set_req(0, 0, 8'd0, 2'b00);
    check("t1_calc_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("t1_done_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 143);
    check("t1_id", bus.out_id, 0);
    @(posedge clk); #1;
    check("t1_count", bus.op_count, 1);
    check("t1_after_valid", bus.out_valid, 0);

    run_op(1, 8'd255, 2'b10, 1785, "x7_max");
    run_op(1, 8'd255, 2'b11, 2040, "x8_max");
    run_op(1, 8'd128, 2'b01, 384,  "x3_128");
    check("count_4", bus.op_count, 4);

    // Both valid from reset: strict alternation starting with req0
    do_reset();
    set_req(0, 1, 8'd10, 2'b01);
    set_req(1, 1, 8'd20, 2'b11);
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        check("alt_id", bus.out_id, n % 2);
        check("alt_data", bus.out_data, (n % 2) ? 160 : 30);
        n++;
      end
    end
    check("alt_done", n, 6);
    @(posedge clk); #1;
    set_req(0, 0, 8'd0, 2'b00);
    set_req(1, 0, 8'd0, 2'b00);
    check("alt_count", bus.op_count, 6);

    // Stall in DONE for five cycles while req1 waits
    bus.out_ready = 1'b0;
    set_req(0, 1, 8'd5, 2'b11);
    wait_ready(0, "stall_ready");
    @(posedge clk); #1;
    set_req(0, 0, 8'd0, 2'b00);
    set_req(1, 1, 8'd9, 2'b00);
    wait_valid("stall_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, 40);
      check("stall_busy", bus.busy, 1);
      check("stall_ready0", bus.req0_ready, 0);
      check("stall_ready1", bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    set_req(1, 0, 8'd0, 2'b00);
    @(posedge clk); #1;
    check("stall_release_count", bus.op_count, 7);
    check("stall_release_valid", bus.out_valid, 0);

    // Reset during CALC discards the operation; pending req0 is then served
    set_req(0, 1, 8'd7, 2'b01);
    wait_ready(0, "abort_ready");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_data", bus.out_data, 0);
    check("abort_count", bus.op_count, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_ready0", bus.req0_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_valid("abort_served_valid");
    check("abort_served_data", bus.out_data, 21);
    check("abort_served_id", bus.out_id, 0);
    @(posedge clk); #1;
    set_req(0, 0, 8'd0, 2'b00);
    check("abort_served_count", bus.op_count, 1);

    // op_count wraps after 256 completions
    do_reset();
    set_req(0, 1, 8'd1, 2'b00);
    n = 0;
    for (int k = 0; k < 900 && n < 256; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (n == 255) check("wrap_pre", bus.op_count, 255);
        n++;
      end
    end
    check("wrap_done", n, 256);
    @(posedge clk); #1;
    set_req(0, 0, 8'd0, 2'b00);
    check("wrap_count", bus.op_count, 0);

    // Randomized traffic, rare single-cycle resets
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_req(0, $urandom_range(0, 1), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      set_req(1, $urandom_range(0, 1), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 0, 8'd0, 2'b00);
    set_req(1, 0, 8'd0, 2'b00);
    got = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
